control_sequencer: RTL and testbench
====================================

Name: control_sequencer

Overview:
- Hardwired control unit for the 32-bit RISC datapath.
- Generates, cycle by cycle, the bus-enable, register-load and ALU-select strobes the datapath consumes: PCout, MARin, Read, MDRin, IRin, Yin, Zin, Zlowout/Zhighout, HIin/LOin, Rin/Rout.
- Steps through fetch and execute from the instruction word held in the datapath IR.
- Sits beside the datapath in the CPU top level.

Parameters:
- NUM_REGS, 16, number of general registers; width of the Rin/Rout one-hot buses.
- OPW, 5, width of the opcode field (IR[31:27]) and of alu_op.

Ports:
- Clock  in  1  system clock; all state changes on rising edge.
- reset  in  1  synchronous, active-high reset.
- IR  in  32  instruction register contents from the datapath. Fields: opcode IR[31:27], Ra IR[26:23], Rb IR[22:19], Rc IR[18:15].
- Stop  in  1  halt request, sampled only in the last execute state of an instruction.
- PCout, Zhighout, Zlowout, MDRout, HIout, LOout  out  1 each  bus drive enables.
- PCin, IncPC, MARin, MDRin, IRin, Yin, Zin, HIin, LOin  out  1 each  register load strobes.
- Read  out  1  memory read strobe into MDR.
- Rin  out  NUM_REGS  one-hot general-register load.
- Rout  out  NUM_REGS  one-hot general-register bus drive.
- alu_op  out  OPW  ALU operation select; equals the opcode in T4, 0 otherwise.
- Run  out  1  high while executing; low in RST and HALTED.
- Clear  out  1  high in RST only; clears datapath registers.

Behaviour:
- Moore machine: every output is a function of the state register and IR only. One state per clock.
- States: RST, T0, T1, T2, T3, T4, T5, T6, HALTED.
- reset=1 at a rising edge moves the state to RST from any state, including mid-instruction.
- In RST:
  - All outputs are 0, except Clear=1.
  - Rin=0, Rout=0, alu_op=0, Run=0.
  - Next state is T0 once reset=0.
- T0: PCout=1, MARin=1, IncPC=1, PCin=1. PC+1 is written at the end of the cycle. Next state T1.
- T1: Read=1, MDRin=1. Next state T2.
- T2: MDRout=1, IRin=1. IR is valid from T3 onward. Next state T3 if the opcode is supported; otherwise T0 (unknown opcode = NOP).
- Supported opcodes:
  - ADD 00011, SUB 00100, AND 00101, OR 00110, SHR 00111, SHL 01000, ROR 01001, ROL 01010, MUL 01111, DIV 10000.
  - NOP 11010 and HALT 11011.
- NOP: leaves T2 to T0. Stop is not sampled.
- HALT: leaves T2 to HALTED.
- T3: Rout[Rb]=1, Yin=1.
- T4: Rout[Rc]=1, alu_op=opcode, Zin=1.
- T5:
  - Zlowout=1.
  - Reg-reg ops: Rin[Ra]=1; this is the last state.
  - MUL/DIV: LOin=1, next state T6.
- T6 (MUL/DIV only): Zhighout=1, HIin=1. This is the last state.
- Last-state transition: Stop=1 goes to HALTED, otherwise T0.
- HALTED: all strobes 0, Run=0. The state holds until reset.
- Latency:
  - Reg-reg op: 6 cycles.
  - MUL/DIV: 7 cycles.
  - NOP: 3 cycles.
- Exclusivity:
  - At most one bus driver (PCout, Zhighout, Zlowout, MDRout, HIout, LOout, any Rout bit) is high in any cycle.
  - Rin and Rout are each one-hot or zero.
- Register index 0 is decoded normally (Rin[0]/Rout[0]).
- Ra=Rb=Rc is legal; Rout follows each field independently per state.
- HIout and LOout are reserved for future move instructions and are held 0 in this revision.

Test Plan:
- Assert reset 2 cycles, then release → Clear=1 and all strobes 0 during reset; T0 strobes (PCout, MARin, IncPC, PCin) in the first cycle after release.
- IR=32'h28918000 (AND R1,R2,R3) loaded by T2 → T3 Rout=16'h0004 with Yin; T4 Rout=16'h0008, alu_op=5'b00101, Zin; T5 Zlowout with Rin=16'h0002; T0 on the 7th cycle.
- IR=32'h80B18000 (DIV, Rb=R6, Rc=R3) → T4 alu_op=5'b10000; T5 Zlowout+LOin; T6 Zhighout+HIin; Rin stays 0; T0 follows T6.
- IR opcode 11111 (unsupported) → T2 returns to T0; no Yin, Zin or Rin ever asserted.
- Stop=1 during T5 of an ADD → next state HALTED with Run=0; remains halted 10 cycles; reset restarts at T0.
- reset asserted during T4 of MUL → RST on the next edge, Zin deasserted; after release the sequence restarts at T0, not T5.

Source files
------------

// File: rtl/control_sequencer.sv
// Hardwired fetch/execute sequencer for the 32-bit RISC datapath.
// Moore outputs decoded from the step register and the IR fields.
module control_sequencer #(
  parameter int NUM_REGS = 16,
  parameter int OPW      = 5
) (
  input  logic                Clock,
  input  logic                reset,
  input  logic [31:0]         IR,
  input  logic                Stop,
  output logic                PCout,
  output logic                Zhighout,
  output logic                Zlowout,
  output logic                MDRout,
  output logic                HIout,
  output logic                LOout,
  output logic                PCin,
  output logic                IncPC,
  output logic                MARin,
  output logic                MDRin,
  output logic                IRin,
  output logic                Yin,
  output logic                Zin,
  output logic                HIin,
  output logic                LOin,
  output logic                Read,
  output logic [NUM_REGS-1:0] Rin,
  output logic [NUM_REGS-1:0] Rout,
  output logic [OPW-1:0]      alu_op,
  output logic                Run,
  output logic                Clear
);

  typedef enum logic [3:0] {
    S_RST, S_T0, S_T1, S_T2, S_T3,
    S_T4, S_T5, S_T6, S_HALTED
  } state_t;

  localparam logic [4:0] OP_ADD  = 5'b00011;
  localparam logic [4:0] OP_ROL  = 5'b01010;
  localparam logic [4:0] OP_MUL  = 5'b01111;
  localparam logic [4:0] OP_DIV  = 5'b10000;
  localparam logic [4:0] OP_HALT = 5'b11011;

  localparam logic [NUM_REGS-1:0] ONE = NUM_REGS'(1);

  state_t state, state_nx;

  logic [4:0] opcode;
  logic [3:0] ra, rb, rc;
  logic       is_rr, is_md;
  logic       unused_ir;

  assign opcode    = IR[31:27];
  assign ra        = IR[26:23];
  assign rb        = IR[22:19];
  assign rc        = IR[18:15];
  assign unused_ir = ^IR[14:0];

  assign is_rr = (opcode >= OP_ADD) && (opcode <= OP_ROL);
  assign is_md = (opcode == OP_MUL) || (opcode == OP_DIV);

  // Step register; reset aborts any instruction in flight.
  always_ff @(posedge Clock) begin
    if (reset) state <= S_RST;
    else       state <= state_nx;
  end

  // Step sequencing: fetch, opcode dispatch, execute, halt.
  always_comb begin
    state_nx = state;
    unique case (state)
      S_RST: state_nx = S_T0;
      S_T0:  state_nx = S_T1;
      S_T1:  state_nx = S_T2;
      S_T2: begin
        if (opcode == OP_HALT)   state_nx = S_HALTED;
        else if (is_rr || is_md) state_nx = S_T3;
        else                     state_nx = S_T0;
      end
      S_T3: state_nx = S_T4;
      S_T4: state_nx = S_T5;
      S_T5: begin
        if (is_md)     state_nx = S_T6;
        else if (Stop) state_nx = S_HALTED;
        else           state_nx = S_T0;
      end
      S_T6:     state_nx = Stop ? S_HALTED : S_T0;
      S_HALTED: state_nx = S_HALTED;
      default:  state_nx = S_RST;
    endcase
  end

  // Strobe decode for the current step.
  always_comb begin
    PCout    = 1'b0;
    Zhighout = 1'b0;
    Zlowout  = 1'b0;
    MDRout   = 1'b0;
    HIout    = 1'b0;
    LOout    = 1'b0;
    PCin     = 1'b0;
    IncPC    = 1'b0;
    MARin    = 1'b0;
    MDRin    = 1'b0;
    IRin     = 1'b0;
    Yin      = 1'b0;
    Zin      = 1'b0;
    HIin     = 1'b0;
    LOin     = 1'b0;
    Read     = 1'b0;
    Rin      = '0;
    Rout     = '0;
    alu_op   = '0;
    Run      = 1'b0;
    Clear    = 1'b0;
    unique case (state)
      S_RST: Clear = 1'b1;
      S_T0: begin
        Run   = 1'b1;
        PCout = 1'b1;
        MARin = 1'b1;
        IncPC = 1'b1;
        PCin  = 1'b1;
      end
      S_T1: begin
        Run   = 1'b1;
        Read  = 1'b1;
        MDRin = 1'b1;
      end
      S_T2: begin
        Run    = 1'b1;
        MDRout = 1'b1;
        IRin   = 1'b1;
      end
      S_T3: begin
        Run  = 1'b1;
        Rout = ONE << rb;
        Yin  = 1'b1;
      end
      S_T4: begin
        Run    = 1'b1;
        Rout   = ONE << rc;
        alu_op = OPW'(opcode);
        Zin    = 1'b1;
      end
      S_T5: begin
        Run     = 1'b1;
        Zlowout = 1'b1;
        if (is_md) LOin = 1'b1;
        else       Rin  = ONE << ra;
      end
      S_T6: begin
        Run      = 1'b1;
        Zhighout = 1'b1;
        HIin     = 1'b1;
      end
      S_HALTED: Run = 1'b0;
      default:  Clear = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_control_sequencer.sv
// Scoreboard bench for control_sequencer: a step-list model queues
// expected strobes per cycle; a monitor compares on each falling edge.
module tb_control_sequencer;

  typedef struct packed {
    logic        clear;
    logic        run;
    logic [4:0]  alu;
    logic [15:0] rout;
    logic [15:0] rin;
    logic        pcout, zh, zl, mdrout, hiout, loout;
    logic        pcin, incpc, marin, mdrin, irin;
    logic        yin, zin, hiin, loin, read;
  } ov_t;

  typedef struct packed {
    ov_t v;
    int  step;
  } exp_t;

  localparam int K_RST = 0, K_T0 = 1, K_T1 = 2, K_T2 = 3;
  localparam int K_T3 = 4, K_T4 = 5, K_T5 = 6, K_T6 = 7;
  localparam int K_HALT = 8;

  logic        Clock = 1'b0;
  logic        reset;
  logic [31:0] IR;
  logic        Stop;
  logic        PCout, Zhighout, Zlowout, MDRout, HIout, LOout;
  logic        PCin, IncPC, MARin, MDRin, IRin;
  logic        Yin, Zin, HIin, LOin, Read;
  logic [15:0] Rin, Rout;
  logic [4:0]  alu_op;
  logic        Run, Clear;

  control_sequencer #(.NUM_REGS(16), .OPW(5)) dut (
    .Clock(Clock), .reset(reset), .IR(IR), .Stop(Stop),
    .PCout(PCout), .Zhighout(Zhighout), .Zlowout(Zlowout),
    .MDRout(MDRout), .HIout(HIout), .LOout(LOout),
    .PCin(PCin), .IncPC(IncPC), .MARin(MARin), .MDRin(MDRin),
    .IRin(IRin), .Yin(Yin), .Zin(Zin), .HIin(HIin), .LOin(LOin),
    .Read(Read), .Rin(Rin), .Rout(Rout), .alu_op(alu_op),
    .Run(Run), .Clear(Clear)
  );

  always #5 Clock = ~Clock;

  ov_t act;
  assign act = {Clear, Run, alu_op, Rout, Rin,
                PCout, Zhighout, Zlowout, MDRout, HIout, LOout,
                PCin, IncPC, MARin, MDRin, IRin,
                Yin, Zin, HIin, LOin, Read};

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;
  bit   done  = 0;

  function automatic bit op_rr(input logic [4:0] op);
    return op >= 5'd3 && op <= 5'd10;
  endfunction

  function automatic bit op_md(input logic [4:0] op);
    return op == 5'd15 || op == 5'd16;
  endfunction

  // Expected strobes for a given step of the instruction in ir.
  function automatic ov_t model(input int k, input logic [31:0] ir);
    ov_t o = '0;
    logic [4:0] op = ir[31:27];
    int ra = int'(ir[26:23]);
    int rb = int'(ir[22:19]);
    int rc = int'(ir[18:15]);
    o.run = (k >= K_T0 && k <= K_T6);
    case (k)
      K_RST: o.clear = 1;
      K_T0: begin o.pcout = 1; o.marin = 1; o.incpc = 1; o.pcin = 1; end
      K_T1: begin o.read = 1; o.mdrin = 1; end
      K_T2: begin o.mdrout = 1; o.irin = 1; end
      K_T3: begin o.rout[rb] = 1; o.yin = 1; end
      K_T4: begin o.rout[rc] = 1; o.alu = op; o.zin = 1; end
      K_T5: begin
        o.zl = 1;
        if (op_md(op)) o.loin = 1;
        else           o.rin[ra] = 1;
      end
      K_T6: begin o.zh = 1; o.hiin = 1; end
      default: ;
    endcase
    return o;
  endfunction

  task automatic tick(input int k, input logic [31:0] ir);
    exp_t e;
    @(posedge Clock);
    #1;
    e.v = model(k, ir);
    e.step = k;
    sb.push_back(e);
  endtask

  // Monitor: compare every presented cycle and check bus exclusivity.
  initial begin
    exp_t e;
    int drv;
    while (!done) begin
      @(negedge Clock);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        total++;
        if (act !== e.v) begin
          bad++;
          $display("FAIL strobes step=%0d got=%h want=%h",
                   e.step, act, e.v);
        end
        drv = $countones(act.rout) + int'(act.pcout) + int'(act.zh)
            + int'(act.zl) + int'(act.mdrout) + int'(act.hiout)
            + int'(act.loout);
        total++;
        if (drv > 1 || $countones(act.rin) > 1) begin
          bad++;
          $display("FAIL exclusive step=%0d drivers=%0d rin=%h want<=1",
                   e.step, drv, act.rin);
        end
      end
    end
  end

  // One instruction from entry into T0; abort_at>=0 resets at that step.
  task automatic run_instr(input logic [31:0] ir, input int stop_f,
                           input int abort_at, output bit halted);
    int steps[$];
    logic [4:0] op = ir[31:27];
    int last;
    halted = 0;
    steps = '{K_T0, K_T1, K_T2};
    if (op_rr(op)) steps = {steps, K_T3, K_T4, K_T5};
    if (op_md(op)) steps = {steps, K_T3, K_T4, K_T5, K_T6};
    last = steps[steps.size()-1];
    for (int i = 0; i < steps.size(); i++) begin
      tick(steps[i], ir);
      if (i == 0) IR = ir;
      if (i == steps.size()-1 && stop_f >= 0) Stop = stop_f[0];
      else Stop = ($urandom_range(0, 7) == 0);
      if (i == abort_at) begin
        reset = 1;
        tick(K_RST, ir);
        reset = 0;
        return;
      end
    end
    if (op == 5'd27) halted = 1;
    else if ((last == K_T5 || last == K_T6) && Stop) halted = 1;
  endtask

  task automatic halt_and_restart();
    for (int i = 0; i < 10; i++) begin
      tick(K_HALT, IR);
      IR = $urandom;
      Stop = 1'($urandom);
    end
    reset = 1;
    tick(K_RST, IR);
    reset = 0;
  endtask

  logic [4:0] ops[14] = '{5'd3, 5'd4, 5'd5, 5'd6, 5'd7, 5'd8, 5'd9,
                          5'd10, 5'd15, 5'd16, 5'd26, 5'd27,
                          5'd31, 5'd0};

  initial begin
    bit h;
    logic [31:0] ir;
    reset = 1;
    Stop  = 0;
    IR    = 32'h0;
    tick(K_RST, IR);
    tick(K_RST, IR);
    reset = 0;
    run_instr(32'h28918000, 0, -1, h);
    run_instr(32'h80B18000, 0, -1, h);
    run_instr(32'hF8000000, 0, -1, h);
    run_instr(32'h1891_8000, 1, -1, h);
    if (h) halt_and_restart();
    run_instr({5'd15, 4'd5, 4'd6, 4'd7, 15'h0}, 0, 4, h);
    run_instr({5'd3, 4'd0, 4'd0, 4'd0, 15'h0}, 0, -1, h);
    run_instr({5'd27, 27'h0}, 0, -1, h);
    if (h) halt_and_restart();
    for (int n = 0; n < 250; n++) begin
      ir = $urandom;
      ir[31:27] = ops[$urandom_range(0, 13)];
      run_instr(ir, -1,
                ($urandom_range(0, 15) == 0) ? $urandom_range(0, 4) : -1,
                h);
      if (h) halt_and_restart();
    end
    @(negedge Clock);
    #1;
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL drain left=%0d want=0", sb.size());
    end
    done = 1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
